// File: rtl/key_event_scheduler_if.sv
// Key event output port: registered valid/ready handshake carrying channel index and event code.
interface key_event_scheduler_if #(
  parameter int N_CH = 4
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_ch;
  logic [1:0]      evt_type;

  modport master (output evt_valid, evt_ch, evt_type, input evt_ready);
  modport slave  (input evt_valid, evt_ch, evt_type, output evt_ready);
endinterface

// File: rtl/key_event_scheduler.sv
// Shared-tick debounce plus press/hold/repeat FSM per switch, round-robin onto one event port.
// Macro KEY_EVT_REPEAT_EN enables periodic REPEAT events after HOLD.
module key_event_scheduler #(
  parameter int N_CH           = 4,
  parameter int TICK_DIV       = 3_333_333,
  parameter int STABLE_SAMPLES = 3,
  parameter int HOLD_TICKS     = 30,
  parameter int REPEAT_TICKS   = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       sw_in,
  output logic [N_CH-1:0]       level,
  output logic [N_CH-1:0]       overflow,
  key_event_scheduler_if.master evt
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TCW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {ST_RELEASED, ST_PRESSED, ST_REPEAT} state_e;
  typedef enum logic [1:0] {EVT_PRESS, EVT_RELEASE, EVT_HOLD, EVT_REPEAT} evt_e;

  if (N_CH < 2 || N_CH > 8 || STABLE_SAMPLES < 2 || STABLE_SAMPLES > 8 || TICK_DIV < 1 ||
      HOLD_TICKS < 1 || HOLD_TICKS > 255 || REPEAT_TICKS < 1 || REPEAT_TICKS > 255) begin : g_param_check
    $error("key_event_scheduler: parameter out of range");
  end

  logic [TCW-1:0]            r_tick_cnt;
  logic [N_CH-1:0]           r_sync1, r_sync2, r_level, r_pend_v, r_overflow;
  logic [STABLE_SAMPLES-1:0] r_shift [N_CH];
  state_e                    r_state [N_CH];
  logic [7:0]                r_cnt   [N_CH];
  logic [1:0]                r_pend_t [N_CH];
  logic                      r_evt_valid;
  logic [CH_W-1:0]           r_evt_ch, r_last_grant;
  logic [1:0]                r_evt_type;

  logic                      w_tick, w_out_free, w_grant;
  logic [N_CH-1:0]           w_level_nxt, w_emit;
  logic [STABLE_SAMPLES-1:0] w_shift_nxt [N_CH];
  state_e                    w_state_nxt [N_CH];
  logic [7:0]                w_cnt_nxt   [N_CH];
  logic [7:0]                w_cnt_inc   [N_CH];
  evt_e                      w_emit_type [N_CH];
  logic [CH_W-1:0]           w_grant_ch, w_idx;

  assign w_tick = (r_tick_cnt == TCW'(TICK_DIV - 1));

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
      w_shift_nxt[c] = r_shift[c];
      w_level_nxt[c] = r_level[c];
      w_state_nxt[c] = r_state[c];
      w_cnt_nxt[c]   = r_cnt[c];
      w_cnt_inc[c]   = (r_cnt[c] == 8'hFF) ? r_cnt[c] : r_cnt[c] + 8'd1;
      w_emit[c]      = 1'b0;
      w_emit_type[c] = EVT_PRESS;
      if (w_tick) begin
        w_shift_nxt[c] = {r_shift[c][STABLE_SAMPLES-2:0], r_sync2[c]};
        if (&w_shift_nxt[c])       w_level_nxt[c] = 1'b1;
        else if (~|w_shift_nxt[c]) w_level_nxt[c] = 1'b0;
        // The FSM reacts to the level computed at this same tick edge.
        case (r_state[c])
          ST_RELEASED: if (w_level_nxt[c]) begin
            w_state_nxt[c] = ST_PRESSED;
            w_cnt_nxt[c]   = 8'd0;
            w_emit[c]      = 1'b1;
            w_emit_type[c] = EVT_PRESS;
          end
          ST_PRESSED: begin
            if (!w_level_nxt[c]) begin
              w_state_nxt[c] = ST_RELEASED;
              w_emit[c]      = 1'b1;
              w_emit_type[c] = EVT_RELEASE;
            end else if (w_cnt_inc[c] == 8'(HOLD_TICKS)) begin
              w_state_nxt[c] = ST_REPEAT;
              w_cnt_nxt[c]   = 8'd0;
              w_emit[c]      = 1'b1;
              w_emit_type[c] = EVT_HOLD;
            end else begin
              w_cnt_nxt[c]   = w_cnt_inc[c];
            end
          end
          ST_REPEAT: begin
            if (!w_level_nxt[c]) begin
              w_state_nxt[c] = ST_RELEASED;
              w_emit[c]      = 1'b1;
              w_emit_type[c] = EVT_RELEASE;
            end
`ifdef KEY_EVT_REPEAT_EN
            else if (w_cnt_inc[c] == 8'(REPEAT_TICKS)) begin
              w_cnt_nxt[c]   = 8'd0;
              w_emit[c]      = 1'b1;
              w_emit_type[c] = EVT_REPEAT;
            end else begin
              w_cnt_nxt[c]   = w_cnt_inc[c];
            end
`else
            else begin
              w_cnt_nxt[c]   = r_cnt[c];
            end
`endif
          end
          default: w_state_nxt[c] = ST_RELEASED;
        endcase
      end
    end
  end

  // Round-robin scan begins one past the last granted channel.
  always_comb begin
    w_out_free = !r_evt_valid || evt.evt_ready;
    w_grant    = 1'b0;
    w_grant_ch = '0;
    w_idx      = '0;
    for (int k = 1; k <= N_CH; k++) begin
      w_idx = CH_W'((int'(r_last_grant) + k) % N_CH);
      if (!w_grant && r_pend_v[w_idx]) begin
        w_grant    = 1'b1;
        w_grant_ch = w_idx;
      end
    end
    w_grant = w_grant && w_out_free;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_cnt   <= '0;
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_level      <= '0;
      r_pend_v     <= '0;
      r_overflow   <= '0;
      r_evt_valid  <= 1'b0;
      r_evt_ch     <= '0;
      r_evt_type   <= '0;
      r_last_grant <= CH_W'(N_CH - 1);
      // NOTE: the per-channel arrays are small flop banks, not RAM, so they are cleared by reset like any other register.
      for (int c = 0; c < N_CH; c++) begin
        r_shift[c]  <= '0;
        r_state[c]  <= ST_RELEASED;
        r_cnt[c]    <= '0;
        r_pend_t[c] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      r_sync1    <= sw_in;
      r_sync2    <= r_sync1;
      r_level    <= w_level_nxt;
      for (int c = 0; c < N_CH; c++) begin
        r_shift[c] <= w_shift_nxt[c];
        r_state[c] <= w_state_nxt[c];
        r_cnt[c]   <= w_cnt_nxt[c];
        if (w_emit[c]) begin
          r_pend_v[c] <= 1'b1;
          r_pend_t[c] <= w_emit_type[c];
          if (r_pend_v[c] && !(w_grant && w_grant_ch == CH_W'(c))) r_overflow[c] <= 1'b1;
        end else if (w_grant && w_grant_ch == CH_W'(c)) begin
          r_pend_v[c] <= 1'b0;
        end
      end
      if (w_out_free) begin
        r_evt_valid <= w_grant;
        if (w_grant) begin
          r_evt_ch     <= w_grant_ch;
          r_evt_type   <= r_pend_t[w_grant_ch];
          r_last_grant <= w_grant_ch;
        end
      end
    end
  end

  assign level         = r_level;
  assign overflow      = r_overflow;
  assign evt.evt_valid = r_evt_valid;
  assign evt.evt_ch    = r_evt_ch;
  assign evt.evt_type  = r_evt_type;
endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed bench for key_event_scheduler: TICK_DIV=4, STABLE_SAMPLES=3, HOLD_TICKS=5, REPEAT_TICKS=2.
// Expected handshakes are tagged with the clk edge (counted from reset release) at which they complete.
module tb_key_event_scheduler;
  localparam int N_CH = 4;
  localparam logic [1:0] T_PRESS = 2'b00, T_REL = 2'b01, T_HOLD = 2'b10, T_REP = 2'b11;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N_CH-1:0] sw_in = '0;
  logic [N_CH-1:0] level, overflow;
  int              n_edge;
  int              n_vec = 0;
  int              n_err = 0;
  logic [31:0]     mon_q[$];
  logic [31:0]     exp_q[$];

  key_event_scheduler_if #(.N_CH(N_CH)) evt_if ();

  key_event_scheduler #(
    .N_CH(N_CH), .TICK_DIV(4), .STABLE_SAMPLES(3), .HOLD_TICKS(5), .REPEAT_TICKS(2)
  ) dut (
    .clk(clk), .reset(rst_n), .sw_in(sw_in), .level(level), .overflow(overflow), .evt(evt_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) n_edge <= 0;
    else        n_edge <= n_edge + 1;

  function automatic logic [31:0] ev(input int ch, input logic [1:0] t, input int e);
    return {8'(ch), 6'd0, t, 16'(e)};
  endfunction

  // Handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clk)
    if (!rst_n) mon_q.delete();
    else if (evt_if.evt_valid && evt_if.evt_ready)
      mon_q.push_back(ev(int'(evt_if.evt_ch), evt_if.evt_type, n_edge + 1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic at_edge(input int k);
    while (n_edge < k) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset(input logic ready);
    rst_n = 1'b0;
    sw_in = '0;
    evt_if.evt_ready = ready;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic check_out(input string tag, input logic v, input int ch, input logic [1:0] t);
    check({tag, "_valid"}, 32'(evt_if.evt_valid), 32'(v));
    check({tag, "_ch"},    32'(evt_if.evt_ch),    32'(ch));
    check({tag, "_type"},  32'(evt_if.evt_type),  32'(t));
  endtask

  task automatic check_events(input string tag);
    check({tag, "_count"}, 32'(mon_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_evt%0d", tag, i), (i < mon_q.size()) ? mon_q[i] : 32'hFFFF_FFFF, exp_q[i]);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    evt_if.evt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_out("rst", 1'b0, 0, T_PRESS);
    check("rst_level", 32'(level), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);

    // Clean press and release on ch0.
    do_reset(1'b1);
    at_edge(4);  sw_in[0] = 1'b1;
    at_edge(15); check("A_level_pre", 32'(level), 32'h0);
    at_edge(16); check("A_level", 32'(level), 32'h1);
                 check("A_valid_pre", 32'(evt_if.evt_valid), 32'h0);
    at_edge(17); check_out("A_press", 1'b1, 0, T_PRESS);
    at_edge(18); check("A_valid_drop", 32'(evt_if.evt_valid), 32'h0);
    at_edge(20); sw_in[0] = 1'b0;
    at_edge(32); check("A_level_rel", 32'(level), 32'h0);
    at_edge(33); check_out("A_release", 1'b1, 0, T_REL);
    at_edge(40);
    exp_q.push_back(ev(0, T_PRESS, 18));
    exp_q.push_back(ev(0, T_REL, 34));
    check_events("A");

    // Bouncing ch1 never settles.
    do_reset(1'b1);
    for (int k = 0; k < 12; k++) begin
      at_edge(4 + 4 * k);
      sw_in[1] = ((k % 2) == 0);
      check("B_level", 32'(level), 32'h0);
    end
    at_edge(64);
    check("B_ovf", 32'(overflow), 32'h0);
    check_events("B");

    // Hold and repeat on ch2.
    do_reset(1'b1);
    at_edge(4);  sw_in[2] = 1'b1;
    at_edge(52); sw_in[2] = 1'b0;
    at_edge(64); check("C_level_rel", 32'(level), 32'h0);
    at_edge(72);
    exp_q.push_back(ev(2, T_PRESS, 18));
    exp_q.push_back(ev(2, T_HOLD, 38));
`ifdef KEY_EVT_REPEAT_EN
    exp_q.push_back(ev(2, T_REP, 46));
    exp_q.push_back(ev(2, T_REP, 54));
    exp_q.push_back(ev(2, T_REP, 62));
`endif
    exp_q.push_back(ev(2, T_REL, 66));
    check_events("C");

    // All channels at once: round-robin order, next round restarts at ch0.
    do_reset(1'b1);
    at_edge(4);  sw_in = 4'hF;
    at_edge(16); check("D_level", 32'(level), 32'hF);
    at_edge(20); sw_in = 4'h0;
    at_edge(44);
    for (int c = 0; c < N_CH; c++) exp_q.push_back(ev(c, T_PRESS, 18 + c));
    for (int c = 0; c < N_CH; c++) exp_q.push_back(ev(c, T_REL, 34 + c));
    check_events("D");

    // Backpressure on ch3: release gets overwritten by the second press.
    do_reset(1'b0);
    at_edge(4);  sw_in[3] = 1'b1;
    at_edge(17); check_out("E_hold1", 1'b1, 3, T_PRESS);
    at_edge(20); sw_in[3] = 1'b0;
    at_edge(32); sw_in[3] = 1'b1;
    at_edge(40); check("E_ovf_pre", 32'(overflow), 32'h0);
                 check_out("E_hold2", 1'b1, 3, T_PRESS);
    at_edge(45); check("E_ovf", 32'(overflow), 32'h8);
                 check_out("E_hold3", 1'b1, 3, T_PRESS);
    at_edge(48); evt_if.evt_ready = 1'b1;
    at_edge(56);
    exp_q.push_back(ev(3, T_PRESS, 49));
    exp_q.push_back(ev(3, T_PRESS, 50));
    check_events("E");
    check("E_ovf_sticky", 32'(overflow), 32'h8);

    // Reset in the middle of traffic discards everything.
    do_reset(1'b0);
    at_edge(4);  sw_in = 4'b1100;
    at_edge(20); check_out("F_inflight", 1'b1, 2, T_PRESS);
    #1 rst_n = 1'b0;
    #1;
    check_out("F_rst", 1'b0, 0, T_PRESS);
    check("F_rst_level", 32'(level), 32'h0);
    check("F_rst_ovf", 32'(overflow), 32'h0);
    sw_in = '0;
    evt_if.evt_ready = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    at_edge(40);
    check("F_valid_after", 32'(evt_if.evt_valid), 32'h0);
    check_events("F");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/key_event_scheduler.md
Name: key_event_scheduler

Overview:
- Multi-channel switch front end that shares one sample-tick generator across N_CH switch inputs.
- Per channel: synchronises and debounces the switch, then runs a press/hold/repeat state machine that produces key events.
- Pending events from all channels are arbitrated round-robin onto a single registered valid/ready event port.
- Sits between the board switches and the application FSMs, replacing per-switch debounce instances.

Parameters:
- N_CH, 4, number of switch channels (2..8).
- TICK_DIV, 3_333_333, clk cycles per sample tick.
- STABLE_SAMPLES, 3, consecutive equal samples required to change the debounced level (2..8).
- HOLD_TICKS, 30, ticks from PRESS to HOLD event (1..255).
- REPEAT_TICKS, 10, ticks between REPEAT events (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- sw_in  in  N_CH  raw switch inputs, asynchronous to clk.
- level  out  N_CH  debounced switch levels.
- evt_valid  out  1  event output valid.
- evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready.
- evt_ch  out  clog2(N_CH), min 1  channel index of the event.
- evt_type  out  2  event code: 00 PRESS, 01 RELEASE, 10 HOLD, 11 REPEAT.
- overflow  out  N_CH  sticky per-channel event-lost flag.

Behaviour:
- Reset (reset=0, asynchronous): all registers clear.
  - level=0, evt_valid=0, evt_ch=0, evt_type=0, overflow=0.
  - Tick counter=0, shift registers=0, all FSMs=RELEASED, pending slots empty, last_grant=N_CH-1.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick=1 for exactly one cycle when counter==TICK_DIV-1.
- Synchroniser: 2-flop synchroniser per channel, updates every clk.
- Debounce, at each tick edge:
  - Shift the synchronised bit into a STABLE_SAMPLES-bit shift register.
  - level[ch] is computed from the new shift value at the same edge.
  - level goes 1 if all bits are 1, goes 0 if all bits are 0, otherwise holds.
- Per-channel FSM (advances only at tick edges, evaluated with the new level):
  - RELEASED: level rises -> PRESSED, cnt=0, emit PRESS.
  - PRESSED: level falls -> RELEASED, emit RELEASE. Otherwise cnt++; cnt reaches HOLD_TICKS -> REPEAT, cnt=0, emit HOLD.
  - REPEAT: level falls -> RELEASED, emit RELEASE. Otherwise cnt++; cnt reaches REPEAT_TICKS -> cnt=0, emit REPEAT.
  - cnt is 8 bits and never wraps.
- Pending slot: one per channel (valid + 2-bit type), written at the emit edge.
  - Emit while the slot is full and not granted that cycle: the new event overwrites the old one and overflow[ch] sets.
  - overflow[ch] stays set until reset.
  - Emit in the same cycle the slot is granted: the grant takes the old event, the slot loads the new one, no overflow.
- Arbiter:
  - Output register is free when evt_valid==0 or (evt_valid && evt_ready).
  - When free, scan pending slots starting at (last_grant+1) mod N_CH, wrapping, and take the first valid slot.
  - On a grant: load evt_ch/evt_type, set evt_valid, clear that slot, update last_grant.
  - Free with nothing pending: evt_valid goes 0.
  - evt_ch and evt_type stay stable while evt_valid=1 and evt_ready=0.
  - Throughput: 1 event per clk.
- Latency: evt_valid rises 1 clk after the tick edge that emits the event, provided the output register is free.
- Reset asserted mid-operation: any pending or in-flight event is discarded; no partial event appears after release of reset.

Optional Feature:
- Macro KEY_EVT_REPEAT_EN.
- Defined: REPEAT state emits periodic REPEAT events as described above.
- Undefined: after HOLD the FSM stays in REPEAT with cnt frozen and emits nothing until release.
  - evt_type 11 is never produced.
  - REPEAT_TICKS is ignored.

Test Plan:
(Common settings: TICK_DIV=4, STABLE_SAMPLES=3, HOLD_TICKS=5, REPEAT_TICKS=2, N_CH=4.)
- Reset: assert reset=0 mid-stream with events pending -> all outputs 0 immediately; evt_valid stays 0 after release until a new emit.
- Clean press: sw_in[0]=1 held for 4 ticks, evt_ready=1 -> level[0]=1 at the 3rd tick after sync; {evt_ch=0, evt_type=00} for 1 cycle, 1 clk later. Release -> {0, 01}.
- Bounce: sw_in[1] toggled every tick for 12 ticks -> level[1]=0 throughout, no events, overflow=0.
- Hold/repeat: sw_in[2]=1 held 12 ticks -> PRESS, HOLD 5 ticks later, REPEAT every 2 ticks; release -> RELEASE. Without macro -> no 11 events.
- Arbitration: all four sw_in rise in the same cycle, evt_ready=1 -> PRESS events on 4 consecutive cycles, evt_ch order 0,1,2,3; the next round starts at ch0.
- Backpressure: evt_ready=0; ch3 press, release, press -> output holds {3,00} stable, overflow[3]=1. Set evt_ready=1 -> next event is {3,00} (the second press); the RELEASE is lost.
